flash_line_arbiter: RTL and testbench
=====================================

FLASH_LINE_ARBITER -- requirements
Module: flash_line_arbiter

Interface
REQ-001 Parameter LINE_SIZE, default 128, flash line width in bits.
REQ-002 Parameter ADDR_W, default 24, flash byte-address width.
REQ-003 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  level request from requester 0/1; held high until its done pulse.
REQ-006 addr0, addr1  input  ADDR_W each  requested byte address; sampled only at grant.
REQ-007 gnt0, gnt1  output  1 each  high from grant until the done pulse of that requester.
REQ-008 done0, done1  output  1 each  one-cycle pulse: line buffer valid for that requester.
REQ-009 line  output  LINE_SIZE  registered line buffer, shared by both requesters.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 fr_addr  output  ADDR_W  line-aligned address to flash reader (low 4 bits zero).
REQ-012 fr_rd  output  1  one-cycle read strobe to flash reader.
REQ-013 fr_done  input  1  one-cycle completion pulse from flash reader.
REQ-014 fr_line  input  LINE_SIZE  line data from flash reader; valid in the fr_done cycle.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, BUSY, RESP.
REQ-016 IDLE: no request -> stay; any request -> select winner, register {addr[ADDR_W-1:4],4'b0} into fr_addr, set gnt of winner, go ISSUE.
REQ-017 ISSUE: fr_rd SHALL be high for exactly this one cycle; next state BUSY.
REQ-018 BUSY: on fr_done capture fr_line into line buffer, go RESP; otherwise stay, no timeout.
REQ-019 RESP: done of granted requester high for this one cycle; gnt cleared at end of cycle; last-winner pointer updated; next state IDLE.
REQ-020 Arbitration SHALL be round-robin: with both requesting, the requester not served last wins; pointer reset value favours requester 0.
REQ-021 A single requester SHALL be served back-to-back, with at most one idle cycle between its RESP and the next ISSUE.
REQ-022 Exactly one transaction outstanding; requests arriving while busy are ignored until IDLE.
REQ-023 A request that drops during ISSUE/BUSY SHALL NOT abort: the read completes, line is updated, done still pulses.
REQ-024 fr_done outside BUSY SHALL be ignored (no line update, no done).
REQ-025 line SHALL change only on the fr_done cycle in BUSY; stable otherwise.
REQ-026 gnt0 and gnt1 SHALL never be high together; done0/done1 likewise.
REQ-027 Grant-to-done latency = 2 + (cycles from fr_rd to fr_done).
REQ-028 fr_addr SHALL remain stable from ISSUE until leaving RESP.

Reset
REQ-029 HRESETn low: state IDLE, gnt0/gnt1/done0/done1/fr_rd/busy = 0, fr_addr = 0, RR pointer = "last served = 1", immediately and asynchronously.
REQ-030 line buffer SHALL reset to 0.
REQ-031 Reset mid-transaction discards it; no done issued after reset release; flash reader is reset by the same HRESETn.

Structure
REQ-032 Shared package holds FSM state encodings (2-bit) and the line-offset width constant (4).
REQ-033 One sub-module natural: rr_arb2 (2-way round-robin priority selector, combinational select plus pointer register).

Verification
REQ-034 req0 only, addr0=0x012345, reader model fr_done 40 cycles after fr_rd -> fr_addr=0x012340, fr_rd one pulse, done0 at cycle 42 after grant, line = model data.
REQ-035 req0 and req1 raised same cycle after reset -> requester 0 served first, requester 1 granted on next IDLE; repeated twice -> order 0,1,0,1.
REQ-036 req1 held continuously with req0 low -> three consecutive transactions, one idle cycle between RESP and ISSUE.
REQ-037 req0 dropped during BUSY -> transaction completes, done0 still pulses, line updated.
REQ-038 HRESETn asserted in BUSY -> all outputs 0 same cycle, no done after release, next request starts cleanly from IDLE.
REQ-039 Spurious fr_done in IDLE -> line unchanged, no done pulse.

Source files
------------

// File: rtl/flash_line_arbiter_pkg.sv
// Shared definitions for the flash line arbiter.
//   state_t    : 2-bit FSM state encoding (IDLE, ISSUE, BUSY, RESP)
//   LINE_OFS_W : byte-offset width within one flash line; fr_addr clears these bits
package flash_line_arbiter_pkg;

  localparam int LINE_OFS_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/flash_line_arbiter_if.sv
// Arbiter <-> flash reader link.
//   fr_addr : line-aligned read address (arbiter -> reader)
//   fr_rd   : one-cycle read strobe      (arbiter -> reader)
//   fr_done : one-cycle completion pulse (reader -> arbiter)
//   fr_line : line data, valid with fr_done (reader -> arbiter)
interface flash_line_arbiter_if #(
  parameter int LINE_SIZE = 128,
  parameter int ADDR_W    = 24
) ();

  logic [ADDR_W-1:0]    fr_addr;
  logic                 fr_rd;
  logic                 fr_done;
  logic [LINE_SIZE-1:0] fr_line;

  modport master (output fr_addr, fr_rd, input  fr_done, fr_line);
  modport slave  (input  fr_addr, fr_rd, output fr_done, fr_line);

endinterface

// File: rtl/flash_line_arbiter_rr_arb2.sv
// Two-way round-robin selector.
//   req[1:0] : request levels
//   update   : commit 'served' as the last-served requester
//   served   : index of the requester just completed
//   win_vld  : some requester is asking
//   win_idx  : selected requester (the one not served last when both ask)
// The pointer resets to "last served = 1" so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       win_vld,
  output logic       win_idx
);

  logic last_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    last_q <= 1'b1;
    else if (update) last_q <= served;
  end

  always_comb begin
    win_vld = |req;
    win_idx = 1'b0;
    if (&req)        win_idx = ~last_q;
    else if (req[1]) win_idx = 1'b1;
  end

endmodule

// File: rtl/flash_line_arbiter.sv
// Arbitrates two requesters onto a single flash line reader, one read at a time.
//   HCLK, HRESETn   : clock, async active-low reset
//   req0/req1       : level requests, held until the matching done pulse
//   addr0/addr1     : byte addresses, sampled at grant
//   gnt0/gnt1       : grant, high from ISSUE through RESP
//   done0/done1     : one-cycle pulse when 'line' holds that requester's data
//   line            : shared registered line buffer
//   busy            : FSM not in IDLE
//   fr              : flash reader link (fr_addr, fr_rd, fr_done, fr_line)
module flash_line_arbiter
  import flash_line_arbiter_pkg::*;
#(
  parameter int LINE_SIZE = 128,
  parameter int ADDR_W    = 24
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [ADDR_W-1:0]     addr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [LINE_SIZE-1:0]  line,
  output logic                  busy,
  flash_line_arbiter_if.master  fr
);

  state_t                state_q, state_d;
  logic                  gnt_idx_q;
  logic [ADDR_W-1:0]     fr_addr_q;
  logic [LINE_SIZE-1:0]  line_q;
  logic                  win_vld, win_idx;
  logic                  accept, in_resp, rd_strobe;
  logic [ADDR_W-1:0]     sel_addr;

  rr_arb2 u_rr (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req     ({req1, req0}),
    .update  (in_resp),
    .served  (gnt_idx_q),
    .win_vld (win_vld),
    .win_idx (win_idx)
  );

  assign sel_addr = win_idx ? addr1 : addr0;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    in_resp   = 1'b0;
    rd_strobe = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        // Requests are only looked at here, so anything raised mid-transaction waits.
        if (win_vld) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_strobe = 1'b1;
        state_d   = BUSY;
      end
      BUSY:  if (fr.fr_done) state_d = RESP;
      RESP: begin
        in_resp = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      gnt_idx_q <= 1'b0;
      fr_addr_q <= '0;
      line_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_idx_q <= win_idx;
        fr_addr_q <= {sel_addr[ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
      end
      // fr_done outside BUSY is ignored, so the buffer only moves here.
      if (state_q == BUSY && fr.fr_done) line_q <= fr.fr_line;
    end
  end

  // Grant spans ISSUE..RESP, i.e. exactly the non-IDLE states.
  assign gnt0       = busy & ~gnt_idx_q;
  assign gnt1       = busy &  gnt_idx_q;
  assign done0      = in_resp & ~gnt_idx_q;
  assign done1      = in_resp &  gnt_idx_q;
  assign line       = line_q;
  assign fr.fr_addr = fr_addr_q;
  assign fr.fr_rd   = rd_strobe;

endmodule

// File: tb/tb_flash_line_arbiter.sv
module tb_flash_line_arbiter;

  localparam int LS = 128;
  localparam int AW = 24;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          gnt0, gnt1, done0, done1, busy;
  logic [LS-1:0] line;

  logic [LS-1:0] model_line = '0;
  int            rd_delay = 1;
  int            rd_cnt = 0;
  logic          mdl_done = 1'b0;
  logic          spur_done = 1'b0;
  logic          excl_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  flash_line_arbiter_if #(.LINE_SIZE(LS), .ADDR_W(AW)) fr_if ();

  assign fr_if.fr_done = mdl_done | spur_done;
  assign fr_if.fr_line = model_line;

  flash_line_arbiter #(.LINE_SIZE(LS), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .line(line), .busy(busy), .fr(fr_if)
  );

  always #5 HCLK = ~HCLK;

  // Flash reader model: fr_done pulses rd_delay cycles after the fr_rd cycle.
  always @(negedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_cnt   <= 0;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= (!fr_if.fr_rd && rd_cnt == 1);
      if (fr_if.fr_rd)     rd_cnt <= rd_delay;
      else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
    end
  end

  always @(negedge HCLK)
    if ((gnt0 & gnt1) | (done0 & done1)) excl_err <= 1'b1;

  task automatic chk(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for any done pulse; lat = negedges since call (0 if none within maxc).
  task automatic wait_done(input int maxc, output int lat, output logic who, output int rds);
    lat = 0; who = 1'b0; rds = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge HCLK);
      if (fr_if.fr_rd) rds++;
      if (done0 | done1) begin
        lat = k;
        who = done1;
        break;
      end
    end
  endtask

  task automatic wait_rd(input int maxc, output logic seen);
    seen = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge HCLK);
      if (fr_if.fr_rd) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int   lat, rds, nd, nrd;
    int   rd_at[4], dn_at[4];
    logic who, seen, sawd;
    logic [LS-1:0] prev;

    // Reset state
    repeat (2) @(negedge HCLK);
    chk("rst_gnt",  {gnt1, gnt0}, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd",   fr_if.fr_rd, 0);
    chk("rst_addr", fr_if.fr_addr, 0);
    chk("rst_line", line, 0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Single read, 40-cycle reader
    rd_delay   = 40;
    model_line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    addr0 = 24'h012345;
    req0  = 1'b1;
    wait_done(100, lat, who, rds);
    chk("t1_lat",    lat, 42);
    chk("t1_who",    who, 0);
    chk("t1_rd_cnt", rds, 1);
    chk("t1_addr",   fr_if.fr_addr, 24'h012340);
    chk("t1_line",   line, model_line);
    chk("t1_gnt",    {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    @(negedge HCLK);
    chk("t1_gnt_off", {gnt1, gnt0}, 0);
    chk("t1_idle",    busy, 0);

    // Round robin after reset: 0,1,0,1
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    rd_delay = 3;
    addr1 = 24'h00FF17;
    for (int r = 0; r < 2; r++) begin
      req0 = 1'b1; req1 = 1'b1;
      wait_done(30, lat, who, rds);
      chk("rr_first", who, 0);
      chk("rr_first_seen", (lat != 0), 1);
      req0 = 1'b0;
      wait_done(30, lat, who, rds);
      chk("rr_second", who, 1);
      chk("rr_second_addr", fr_if.fr_addr, 24'h00FF10);
      req1 = 1'b0;
    end
    @(negedge HCLK);

    // Back-to-back single requester
    rd_delay = 2;
    nd = 0; nrd = 0;
    req1 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge HCLK);
      if (fr_if.fr_rd && nrd < 4) begin rd_at[nrd] = k; nrd++; end
      if (done1 && nd < 4)        begin dn_at[nd] = k;  nd++;  end
      if (nd == 3) break;
    end
    req1 = 1'b0;
    chk("b2b_count", nd, 3);
    chk("b2b_gap1", rd_at[1] - dn_at[0], 2);
    chk("b2b_gap2", rd_at[2] - dn_at[1], 2);
    @(negedge HCLK);

    // Request dropped during BUSY still completes
    rd_delay   = 10;
    model_line = 128'hA5A5_0000_1111_2222_3333_4444_5555_5A5A;
    addr0 = 24'hABCDEF;
    req0  = 1'b1;
    wait_rd(10, seen);
    chk("drop_rd", seen, 1);
    repeat (2) @(negedge HCLK);
    req0 = 1'b0;
    chk("drop_busy", busy, 1);
    wait_done(30, lat, who, rds);
    chk("drop_done", (lat != 0) && !who, 1);
    chk("drop_line", line, model_line);
    chk("drop_addr", fr_if.fr_addr, 24'hABCDE0);

    // Reset in BUSY
    rd_delay = 20;
    addr0 = 24'h000010;
    req0  = 1'b1;
    wait_rd(10, seen);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_gnt",  {gnt1, gnt0}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", {done1, done0, fr_if.fr_rd}, 0);
    chk("mid_rst_addr", fr_if.fr_addr, 0);
    chk("mid_rst_line", line, 0);
    req0 = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    wait_done(30, lat, who, rds);
    chk("post_rst_nodone", lat, 0);
    rd_delay   = 3;
    model_line = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
    addr0 = 24'h0FFFFF;
    req0  = 1'b1;
    wait_done(30, lat, who, rds);
    chk("post_rst_lat",  lat, 5);
    chk("post_rst_line", line, model_line);
    chk("post_rst_addr", fr_if.fr_addr, 24'h0FFFF0);
    req0 = 1'b0;
    repeat (2) @(negedge HCLK);

    // Spurious fr_done in IDLE
    prev       = line;
    model_line = 128'h1;
    spur_done  = 1'b1;
    sawd       = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge HCLK);
      spur_done = 1'b0;
      if (done0 | done1) sawd = 1'b1;
    end
    chk("spur_nodone", sawd, 0);
    chk("spur_line", line, prev);
    chk("spur_idle", busy, 0);

    chk("exclusive", excl_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
